// File: rtl/cv32e20_tb_obi_ram.sv
// +--------------------------------------------------------------------------+
// | Module   : cv32e20_tb_obi_ram                                            |
// | Desc     : Dual-port OBI RAM model (instr read-only + data) with fixed   |
// |            response latency, outstanding limit and virtual peripherals.  |
// |            Optional random grant stalls under OBI_RANDOM_STALL_EN.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module cv32e20_tb_obi_ram #(
  parameter int          RAM_ADDR_WIDTH  = 20,
  parameter int          RVALID_LATENCY  = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          DEBUG_CNT_WIDTH = 16,
  parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        debug_req_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int                 c_num_words   = 2 ** (RAM_ADDR_WIDTH - 2);
  localparam int                 c_cnt_w       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cnt_w-1:0] c_max_out     = c_cnt_w'(MAX_OUTSTANDING);
  localparam logic [31:0]        c_addr_status = 32'h2000_0000;
  localparam logic [31:0]        c_addr_exit   = 32'h2000_0004;
  localparam logic [31:0]        c_addr_debug  = 32'h1500_0000;
  localparam logic [31:0]        c_bad_data    = 32'hDEAD_BEEF;
  localparam logic [31:0]        c_pass_code   = 32'd123456789;
  localparam logic [31:0]        c_fail_code   = 32'd1;
  localparam logic [0:0]         c_st_idle     = 1'b0;
  localparam logic [0:0]         c_st_count    = 1'b1;

  logic [31:0] r_mem [c_num_words];

  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic [1:0]       w_rvalid;
  logic [1:0]       w_stall_ok;
  logic [1:0][31:0] w_rd_in;
  logic [1:0][31:0] w_rd_out;

  logic                      w_i_in_ram;
  logic                      w_d_in_ram;
  logic                      w_d_is_periph;
  logic [RAM_ADDR_WIDTH-3:0] w_i_idx;
  logic [RAM_ADDR_WIDTH-3:0] w_d_idx;
  logic [31:0]               w_i_rdata;
  logic [31:0]               w_d_rdata;
  logic                      w_d_wr;
  logic                      w_unused;

  assign w_i_in_ram    = (instr_addr_i[31:RAM_ADDR_WIDTH] == '0);
  assign w_d_in_ram    = (data_addr_i[31:RAM_ADDR_WIDTH] == '0);
  assign w_i_idx       = instr_addr_i[RAM_ADDR_WIDTH-1:2];
  assign w_d_idx       = data_addr_i[RAM_ADDR_WIDTH-1:2];
  assign w_d_is_periph = (data_addr_i == c_addr_status) || (data_addr_i == c_addr_exit) ||
                         (data_addr_i == c_addr_debug);
  assign w_d_wr        = w_gnt[1] & data_we_i;
  assign w_unused      = ^{STALL_SEED, instr_addr_i[1:0]};

  // RAM is read combinationally in the grant cycle, so a same-cycle write lands after the read
  assign w_i_rdata = w_i_in_ram ? r_mem[w_i_idx] : c_bad_data;

  always_comb begin
    w_d_rdata = c_bad_data;
    if (data_we_i || w_d_is_periph) begin
      w_d_rdata = '0;
    end else if (w_d_in_ram) begin
      w_d_rdata = r_mem[w_d_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_d_wr && w_d_in_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          r_mem[w_d_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign w_req   = {data_req_i, instr_req_i};
  assign w_rd_in = {w_d_rdata, w_i_rdata};

  // Index 0 = instruction port, index 1 = data port
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [c_cnt_w-1:0]        r_outstanding;
    logic [RVALID_LATENCY-1:0] r_vld;
    logic [31:0]               r_dat [RVALID_LATENCY];

    assign w_gnt[p]    = rst_ni & w_req[p] & w_stall_ok[p] & (r_outstanding < c_max_out);
    assign w_rvalid[p] = r_vld[RVALID_LATENCY-1];
    assign w_rd_out[p] = w_rvalid[p] ? r_dat[RVALID_LATENCY-1] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_vld         <= '0;
        r_outstanding <= '0;
      end else begin
        r_vld[0] <= w_gnt[p];
        for (int i = 1; i < RVALID_LATENCY; i++) begin
          r_vld[i] <= r_vld[i-1];
        end
        if (w_gnt[p] && !w_rvalid[p]) begin
          r_outstanding <= r_outstanding + 1'b1;
        end else if (!w_gnt[p] && w_rvalid[p]) begin
          r_outstanding <= r_outstanding - 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      r_dat[0] <= w_rd_in[p];
      for (int i = 1; i < RVALID_LATENCY; i++) begin
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

`ifdef OBI_RANDOM_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= STALL_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall_ok = {(r_lfsr[3:2] != 2'b00), (r_lfsr[1:0] != 2'b00)};
`else
  assign w_stall_ok = 2'b11;
`endif

  logic        r_passed;
  logic        r_failed;
  logic        r_exit_valid;
  logic [31:0] r_exit_value;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_passed     <= 1'b0;
      r_failed     <= 1'b0;
      r_exit_valid <= 1'b0;
      r_exit_value <= '0;
    end else if (w_d_wr) begin
      if (data_addr_i == c_addr_status) begin
        if (data_wdata_i == c_pass_code) r_passed <= 1'b1;
        if (data_wdata_i == c_fail_code) r_failed <= 1'b1;
      end
      if (data_addr_i == c_addr_exit) begin
        r_exit_valid <= 1'b1;
        r_exit_value <= data_wdata_i;
      end
    end
  end

  logic [0:0]                 r_dbg_state;
  logic [0:0]                 w_dbg_state_nxt;
  logic [DEBUG_CNT_WIDTH-1:0] r_dbg_cnt;
  logic [DEBUG_CNT_WIDTH-1:0] w_dbg_cnt_nxt;
  logic                       w_dbg_wr;
  logic                       w_debug_req;

  assign w_dbg_wr = w_d_wr && (data_addr_i == c_addr_debug);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dbg_state <= c_st_idle;
      r_dbg_cnt   <= '0;
    end else begin
      r_dbg_state <= w_dbg_state_nxt;
      r_dbg_cnt   <= w_dbg_cnt_nxt;
    end
  end

  // A write always (re)loads the delay, even in the cycle the pulse fires
  always_comb begin
    w_dbg_state_nxt = r_dbg_state;
    w_dbg_cnt_nxt   = r_dbg_cnt;
    case (r_dbg_state)
      c_st_idle: begin
        if (w_dbg_wr) begin
          w_dbg_state_nxt = c_st_count;
          w_dbg_cnt_nxt   = data_wdata_i[DEBUG_CNT_WIDTH-1:0];
        end
      end
      c_st_count: begin
        if (w_dbg_wr) begin
          w_dbg_cnt_nxt = data_wdata_i[DEBUG_CNT_WIDTH-1:0];
        end else if (r_dbg_cnt == '0) begin
          w_dbg_state_nxt = c_st_idle;
        end else begin
          w_dbg_cnt_nxt = r_dbg_cnt - 1'b1;
        end
      end
      default: w_dbg_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_debug_req = (r_dbg_state == c_st_count) && (r_dbg_cnt == '0);
  end

  assign instr_gnt_o    = w_gnt[0];
  assign instr_rvalid_o = w_rvalid[0];
  assign instr_rdata_o  = w_rd_out[0];
  assign data_gnt_o     = w_gnt[1];
  assign data_rvalid_o  = w_rvalid[1];
  assign data_rdata_o   = w_rd_out[1];
  assign debug_req_o    = w_debug_req;
  assign tests_passed_o = r_passed;
  assign tests_failed_o = r_failed;
  assign exit_valid_o   = r_exit_valid;
  assign exit_value_o   = r_exit_value;

endmodule

`default_nettype wire
